// File: rtl/OoO_pkg.sv
// Shared types and defaults for the FLU writeback arbiter.
package OoO_pkg;

    localparam int unsigned ScoreboardIndex = 4;
    localparam int unsigned FluWbDepth      = 2;
    localparam int unsigned FluStarveLimit  = 4;

    typedef struct packed {
        logic [ScoreboardIndex-1:0] idx;
        logic [31:0]                data;
    } flu_wb_entry_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_OC,
        WB_FIFO,
        WB_MDU
    } wb_src_t;

endpackage

// File: rtl/flu_wb_fifo.sv
// In-order holding FIFO for MDU results that lost the writeback port.
module flu_wb_fifo
    import OoO_pkg::*;
#(
    parameter int unsigned DEPTH = FluWbDepth,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  flu_wb_entry_t      push_entry,
    input  logic               pop,
    output flu_wb_entry_t      head,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    flu_wb_entry_t    mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/flu_wb_arbiter.sv
// Shares the FLU writeback port between one-cycle FUs and the MDU; one-cycle results always win.
module flu_wb_arbiter
    import OoO_pkg::*;
#(
    parameter int unsigned DEPTH        = FluWbDepth,
    parameter int unsigned STARVE_LIMIT = FluStarveLimit
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       oc_valid,
    input  logic [ScoreboardIndex-1:0] oc_idx,
    input  logic [31:0]                oc_data,
    input  logic                       mdu_finish,
    input  logic [ScoreboardIndex-1:0] mdu_idx,
    input  logic [31:0]                mdu_result,
    output logic                       mdu_ready,
    output logic                       issue_block,
    output logic                       wb_valid,
    output logic [ScoreboardIndex-1:0] wb_idx,
    output logic [31:0]                wb_data,
    output logic [31:0]                conflict_cnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ST_W  = $clog2(STARVE_LIMIT + 1);

    flu_wb_entry_t    fifo_head;
    flu_wb_entry_t    mdu_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [ST_W-1:0]  starve_cnt;
    wb_src_t          src;

    assign mdu_entry = '{idx: mdu_idx, data: mdu_result};

    flu_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .push_entry (mdu_entry),
        .pop        (pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        src = WB_NONE;
        pop = 1'b0;
        if (!reset && !flush) begin
            if (oc_valid) begin
                src = WB_OC;
            end else if (!fifo_empty) begin
                src = WB_FIFO;
                pop = 1'b1;
            end else if (mdu_finish) begin
                src = WB_MDU;
            end
        end
    end

    // A bypassed MDU result is never pushed; only results that lose the port queue up.
    always_comb begin
        mdu_ready = !reset && (flush || !fifo_full || pop);
        push      = mdu_finish && mdu_ready && !flush && (oc_valid || !fifo_empty);
    end

    always_comb begin
        wb_valid = 1'b0;
        wb_idx   = '0;
        wb_data  = '0;
        case (src)
            WB_OC: begin
                wb_valid = 1'b1;
                wb_idx   = oc_idx;
                wb_data  = oc_data;
            end
            WB_FIFO: begin
                wb_valid = 1'b1;
                wb_idx   = fifo_head.idx;
                wb_data  = fifo_head.data;
            end
            WB_MDU: begin
                wb_valid = 1'b1;
                wb_idx   = mdu_idx;
                wb_data  = mdu_result;
            end
            default: ;
        endcase
    end

    assign issue_block = reset || fifo_full || (starve_cnt >= ST_W'(STARVE_LIMIT));

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            starve_cnt <= '0;
        end else if (fifo_empty || pop) begin
            starve_cnt <= '0;
        end else if (oc_valid && (starve_cnt < ST_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + ST_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (oc_valid && (!fifo_empty || mdu_finish) && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(mdu_finish && !mdu_ready));
            assert (!(oc_valid && issue_block));
        end
    end

endmodule

// File: tb/tb_flu_wb_arbiter.sv
// Randomized bench for flu_wb_arbiter against a queue-based reference model.
module tb_flu_wb_arbiter;
    import OoO_pkg::*;

    localparam int unsigned D = FluWbDepth;
    localparam int unsigned L = FluStarveLimit;

    logic                       clock = 1'b0;
    logic                       reset;
    logic                       flush;
    logic                       oc_valid;
    logic [ScoreboardIndex-1:0] oc_idx;
    logic [31:0]                oc_data;
    logic                       mdu_finish;
    logic [ScoreboardIndex-1:0] mdu_idx;
    logic [31:0]                mdu_result;
    logic                       mdu_ready;
    logic                       issue_block;
    logic                       wb_valid;
    logic [ScoreboardIndex-1:0] wb_idx;
    logic [31:0]                wb_data;
    logic [31:0]                conflict_cnt;

    flu_wb_arbiter #(
        .DEPTH        (D),
        .STARVE_LIMIT (L)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .oc_valid     (oc_valid),
        .oc_idx       (oc_idx),
        .oc_data      (oc_data),
        .mdu_finish   (mdu_finish),
        .mdu_idx      (mdu_idx),
        .mdu_result   (mdu_result),
        .mdu_ready    (mdu_ready),
        .issue_block  (issue_block),
        .wb_valid     (wb_valid),
        .wb_idx       (wb_idx),
        .wb_data      (wb_data),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clock = ~clock;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state: pending MDU results in arrival order.
    flu_wb_entry_t     q[$];
    int unsigned       starve = 0;
    longint unsigned   conf   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_block();
        return (q.size() == D) || (starve >= L);
    endfunction

    function automatic bit m_ready(input bit ov, input bit fl);
        return fl || (q.size() < D) || (!ov && q.size() > 0);
    endfunction

    task automatic step(input bit ov, input logic [ScoreboardIndex-1:0] oi, input logic [31:0] od,
                        input bit mf, input logic [ScoreboardIndex-1:0] mi, input logic [31:0] md,
                        input bit fl, input bit rs);
        bit              e_valid;
        logic [63:0]     e_idx;
        logic [63:0]     e_data;
        bit              e_ready;
        bit              popped;
        int unsigned     sz;
        flu_wb_entry_t   ent;
        reset      = rs;
        flush      = fl;
        oc_valid   = ov;
        oc_idx     = oi;
        oc_data    = od;
        mdu_finish = mf;
        mdu_idx    = mi;
        mdu_result = md;
        #1;
        sz     = q.size();
        e_idx  = '0;
        e_data = '0;
        if (rs) begin
            check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
            check("rst_mdu_ready", {63'd0, mdu_ready}, 64'd0);
            check("rst_issue_block", {63'd0, issue_block}, 64'd1);
            q.delete();
            starve = 0;
            conf   = 0;
        end else begin
            check("issue_block", {63'd0, issue_block}, {63'd0, m_block()});
            check("conflict_cnt", {32'd0, conflict_cnt}, conf);
            popped  = !fl && !ov && sz > 0;
            e_ready = m_ready(ov, fl);
            e_valid = 1'b0;
            if (!fl) begin
                if (ov) begin
                    e_valid = 1'b1; e_idx = oi; e_data = od;
                end else if (sz > 0) begin
                    e_valid = 1'b1; e_idx = q[0].idx; e_data = q[0].data;
                end else if (mf) begin
                    e_valid = 1'b1; e_idx = mi; e_data = md;
                end
            end
            check("wb_valid", {63'd0, wb_valid}, {63'd0, e_valid});
            check("wb_idx", {60'd0, wb_idx}, e_idx);
            check("wb_data", {32'd0, wb_data}, e_data);
            check("mdu_ready", {63'd0, mdu_ready}, {63'd0, e_ready});
            if (ov && (sz > 0 || mf) && conf < 64'hFFFF_FFFF) conf++;
            if (fl || sz == 0 || popped) starve = 0;
            else if (ov && starve < L) starve++;
            if (fl) begin
                q.delete();
            end else begin
                if (popped) void'(q.pop_front());
                if (mf && e_ready && (ov || sz > 0)) begin
                    ent.idx  = mi;
                    ent.data = md;
                    q.push_back(ent);
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit ov, mf, fl, rs;
        reset = 1'b1; flush = 1'b0; oc_valid = 1'b0; oc_idx = '0; oc_data = '0;
        mdu_finish = 1'b0; mdu_idx = '0; mdu_result = '0;
        @(negedge clock);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle();

        // Lone MDU result bypasses.
        step(0, 0, 0, 1, 3, 32'h1234, 0, 0);
        idle();
        // Collision: oc wins, MDU result follows next cycle.
        step(1, 1, 32'hA, 1, 5, 32'hB, 0, 0);
        idle();
        idle();
        // Fill FIFO with back-to-back oc, then drain.
        step(1, 2, 32'h20, 1, 6, 32'h60, 0, 0);
        step(1, 3, 32'h30, 1, 7, 32'h70, 0, 0);
        idle();
        idle();
        idle();
        // Starvation of a single entry.
        step(1, 4, 32'h40, 1, 8, 32'h80, 0, 0);
        for (int unsigned i = 0; i < L; i++) step(1, 4'(i), 32'h100 + i, 0, 0, 0, 0, 0);
        idle();
        idle();
        // Flush with a full FIFO.
        step(1, 2, 32'h22, 1, 9, 32'h90, 0, 0);
        step(1, 3, 32'h33, 1, 10, 32'hA0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        // Reset with one pending entry.
        step(1, 1, 32'h11, 1, 11, 32'hB0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        idle();

        for (int unsigned n = 0; n < 800; n++) begin
            rs = ($urandom_range(0, 99) < 2);
            fl = !rs && ($urandom_range(0, 99) < 5);
            ov = !rs && !m_block() && ($urandom_range(0, 99) < 65);
            mf = !rs && m_ready(ov, fl) && ($urandom_range(0, 99) < 55);
            step(ov, 4'($urandom), $urandom, mf, 4'($urandom), $urandom, fl, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
